// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared types and helpers for the APB memory slave.
//   apb_state_e  : slave FSM states (IDLE, WAIT, RESP)
//   APB_OKAY/ERR : pslverr encodings
//   lane_count   : number of byte lanes in a data word
//   lane_bits    : address bits that select a byte inside a word
//   idx_width    : width of a word index into a DEPTH-entry array
// -----------------------------------------------------------------------------
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_state_e;

    localparam logic APB_OKAY = 1'b0;
    localparam logic APB_ERR  = 1'b1;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int lane_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_slv_mem_array.sv
// -----------------------------------------------------------------------------
// apb_slv_mem_array
// DEPTH x DATA_W register array with per-byte-lane write enables and a
// registered read port. The whole array and the read register clear
// asynchronously on rst.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   wr_lane    : one enable per byte lane; all zero means no write
//   idx        : word index shared by write and read (never both in a cycle)
//   wr_data    : write data
//   rd_en      : load rdata from mem[idx] on this edge
//   rd_clr     : load rdata with zero on this edge (wins over rd_en)
//   rdata      : registered read data, holds between loads
// -----------------------------------------------------------------------------
module apb_slv_mem_array
    import apb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    localparam int LANES = lane_count(DATA_W),
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LANES-1:0]  wr_lane,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (wr_lane[l]) begin
                    mem[idx][l*8 +: 8] <= wr_data[l*8 +: 8];
                end
            end
            if (rd_clr) begin
                rdata <= '0;
            end else if (rd_en) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
// APB3/APB4 memory-mapped slave backed by a DEPTH x DATA_W register file,
// with programmable wait states, base-address decode, error response for
// misaligned / out-of-range accesses, abort detection and a saturating
// error counter.
//
// Optional feature: define APB_SLV_PSTRB_EN to add the pstrb port and
// byte-lane-masked writes. Without it every write updates the full word.
//
// Ports:
//   pclk, preset  : clock, asynchronous active-high reset
//   psel, penable : APB select and access-phase qualifiers
//   pwrite        : 1 = write, 0 = read
//   paddr, pwdata : byte address, write data
//   pstrb         : byte lane strobes (APB_SLV_PSTRB_EN only)
//   prdata        : read data, registered, valid with pready on reads
//   pready        : registered, high for exactly one cycle per transfer
//   pslverr       : error response, meaningful only with pready
//   err_count     : saturating count of error responses and aborts
//   fsm_state     : debug view of the FSM state (apb_state_e encoding)
//
// Handshake: a transfer starts with a setup cycle (psel=1, penable=0) that
// the slave samples in IDLE; address, direction, data and strobes are
// latched there and never re-sampled. The master then holds psel=penable=1
// until it sees pready=1; the transfer completes in that cycle. Dropping
// psel or penable before pready is an abort. penable=1 seen in IDLE without
// a preceding setup is ignored apart from counting it as an error.
// -----------------------------------------------------------------------------
module apb_mem_slave
    import apb_pkg::*;
#(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 32,
    parameter int                DEPTH       = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int                WAIT_CYCLES = 0
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
`ifdef APB_SLV_PSTRB_EN
    input  logic [DATA_W/8-1:0]   pstrb,
`endif
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [7:0]            err_count,
    output logic [1:0]            fsm_state
);

    localparam int                LANES     = lane_count(DATA_W);
    localparam int                LB        = lane_bits(DATA_W);
    localparam int                IDX_W     = idx_width(DEPTH);
    localparam logic [ADDR_W-1:0] LANE_MASK = ADDR_W'(LANES - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [3:0]        WAIT_INIT = 4'(WAIT_CYCLES);

    apb_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       pready_d, pslverr_d;
    logic       latch, exec, err_inc;

    // ---------------- address decode (live bus) ----------------
    logic [ADDR_W-1:0] off, word;
    logic              dec_err;
    logic [IDX_W-1:0]  dec_idx;
    logic [LANES-1:0]  strb_in;

    assign off     = paddr - BASE_ADDR;
    assign word    = off >> LB;
    assign dec_err = (paddr < BASE_ADDR) || ((off & LANE_MASK) != '0) || (word >= DEPTH_A);
    assign dec_idx = word[IDX_W-1:0];

`ifdef APB_SLV_PSTRB_EN
    assign strb_in = pstrb;
`else
    assign strb_in = '1;
`endif

    // ---------------- setup-phase latch ----------------
    logic              lat_err, lat_write;
    logic [IDX_W-1:0]  lat_idx;
    logic [DATA_W-1:0] lat_wdata;
    logic [LANES-1:0]  lat_strb;

    // A zero-wait transfer executes on the setup edge itself, before the
    // latch holds anything, so execution takes the live decode in IDLE and
    // the latched copy otherwise.
    logic              x_err, x_write;
    logic [IDX_W-1:0]  x_idx;
    logic [DATA_W-1:0] x_wdata;
    logic [LANES-1:0]  x_strb;

    assign x_err   = (state_q == IDLE) ? dec_err : lat_err;
    assign x_write = (state_q == IDLE) ? pwrite  : lat_write;
    assign x_idx   = (state_q == IDLE) ? dec_idx : lat_idx;
    assign x_wdata = (state_q == IDLE) ? pwdata  : lat_wdata;
    assign x_strb  = (state_q == IDLE) ? strb_in : lat_strb;

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = APB_OKAY;
        latch     = 1'b0;
        exec      = 1'b0;
        err_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    latch = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        exec    = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WAIT_INIT;
                        state_d = WAIT;
                    end
                end else if (psel && penable) begin
                    err_inc = 1'b1;
                end
            end
            WAIT: begin
                if (!(psel && penable)) begin
                    state_d = IDLE;
                    err_inc = 1'b1;
                end else if (cnt_q == 4'd1) begin
                    exec    = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (exec) begin
            pready_d  = 1'b1;
            pslverr_d = x_err ? APB_ERR : APB_OKAY;
            if (x_err) begin
                err_inc = 1'b1;
            end
        end
    end

    // ---------------- state registers ----------------
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready    <= 1'b0;
            pslverr   <= 1'b0;
            err_count <= '0;
            lat_err   <= 1'b0;
            lat_write <= 1'b0;
            lat_idx   <= '0;
            lat_wdata <= '0;
            lat_strb  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pready  <= pready_d;
            pslverr <= pslverr_d;
            if (err_inc && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (latch) begin
                lat_err   <= dec_err;
                lat_write <= pwrite;
                lat_idx   <= dec_idx;
                lat_wdata <= pwdata;
                lat_strb  <= strb_in;
            end
        end
    end

    assign fsm_state = state_q;

    // ---------------- storage ----------------
    logic [LANES-1:0] wr_lane;
    logic             rd_en, rd_clr;

    assign wr_lane = (exec && x_write && !x_err) ? x_strb : '0;
    assign rd_en   = exec && !x_write && !x_err;
    assign rd_clr  = exec && x_err;

    apb_slv_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (pclk),
        .rst     (preset),
        .wr_lane (wr_lane),
        .idx     (x_idx),
        .wr_data (x_wdata),
        .rd_en   (rd_en),
        .rd_clr  (rd_clr),
        .rdata   (prdata)
    );

endmodule

// File: tb/tb_apb_mem_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_mem_slave
// Two slaves share the APB bus: dut0 with zero wait states and dut3 with
// three. sel3 routes psel to one of them and picks whose outputs the
// transfer task observes.
// -----------------------------------------------------------------------------
module tb_apb_mem_slave;

    logic        pclk = 1'b0;
    logic        preset;
    logic        psel, penable, pwrite, sel3;
    logic [31:0] paddr, pwdata;
    logic        psel0, psel3;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;
    logic [7:0]  err0, err3;
    logic [1:0]  st0, st3;
`ifdef APB_SLV_PSTRB_EN
    logic [3:0]  pstrb;
    logic [3:0]  strb_val = 4'hF;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // ---------------- clock ----------------
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    assign psel0 = psel && !sel3;
    assign psel3 = psel && sel3;

    logic        m_pready, m_pslverr;
    logic [31:0] m_prdata;
    assign m_pready  = sel3 ? pready3  : pready0;
    assign m_pslverr = sel3 ? pslverr3 : pslverr0;
    assign m_prdata  = sel3 ? prdata3  : prdata0;

    apb_mem_slave #(.WAIT_CYCLES(0)) dut0 (
        .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
        .err_count(err0), .fsm_state(st0)
    );

    apb_mem_slave #(.WAIT_CYCLES(3)) dut3 (
        .pclk(pclk), .preset(preset), .psel(psel3), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
`ifdef APB_SLV_PSTRB_EN
        .pstrb(pstrb),
`endif
        .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
        .err_count(err3), .fsm_state(st3)
    );

    // ---------------- driver ----------------
    // Entered and left 1 time unit after a rising edge, so consecutive calls
    // produce back-to-back transfers. acc is the access cycle (1-based) in
    // which pready was seen.
    task automatic apb_xfer(input logic on3, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, output logic [31:0] rd,
                            output logic err, output int acc);
        sel3 = on3; psel = 1'b1; penable = 1'b0;
        pwrite = wr; paddr = addr; pwdata = data;
`ifdef APB_SLV_PSTRB_EN
        pstrb = strb_val;
`endif
        rd = '0; err = 1'b0; acc = 0;
        @(posedge pclk); #1;
        penable = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge pclk);
            if (m_pready) begin
                acc = n; rd = m_prdata; err = m_pslverr;
                break;
            end
            @(posedge pclk); #1;
        end
        if (acc == 0) begin
            checks++; errors++;
            $display("FAIL xfer_timeout: addr %h got no pready expected pready within 40 cycles", addr);
        end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; sel3 = 1'b0;
        paddr = '0; pwdata = '0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        checks++; if (pready0 !== 1'b0 || pready3 !== 1'b0) begin errors++; $display("FAIL rst_pready: got %b/%b expected 0/0", pready0, pready3); end
        checks++; if (pslverr0 !== 1'b0 || pslverr3 !== 1'b0) begin errors++; $display("FAIL rst_pslverr: got %b/%b expected 0/0", pslverr0, pslverr3); end
        checks++; if (prdata0 !== 32'h0 || prdata3 !== 32'h0) begin errors++; $display("FAIL rst_prdata: got %h/%h expected 0", prdata0, prdata3); end
        checks++; if (err0 !== 8'h0 || err3 !== 8'h0) begin errors++; $display("FAIL rst_err_count: got %h/%h expected 0", err0, err3); end
        checks++; if (st0 !== 2'd0 || st3 !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d/%0d expected 0", st0, st3); end
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
    endtask

    task automatic test_zero_wait;
        logic [31:0] rd; logic err; int acc;
        apb_xfer(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL zw_write_latency: got %0d expected 1", acc); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_write_err: got %b expected 0", err); end
        apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, acc);
        checks++; if (acc !== 1) begin errors++; $display("FAIL zw_read_latency: got %0d expected 1", acc); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_read_data: got %h expected deadbeef", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zw_read_err: got %b expected 0", err); end
    endtask

    task automatic test_wait3;
        logic [31:0] rd; logic err; int acc; bit seen;
        apb_xfer(1'b1, 1'b1, 32'h20, 32'h12345678, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL w3_write_latency: got %0d expected 4", acc); end
        apb_xfer(1'b1, 1'b0, 32'h20, 32'h0, rd, err, acc);
        checks++; if (acc !== 4) begin errors++; $display("FAIL w3_read_latency: got %0d expected 4", acc); end
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL w3_read_data: got %h expected 12345678", rd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL w3_read_err: got %b expected 0", err); end
        @(negedge pclk);
        checks++; if (pready3 !== 1'b0) begin errors++; $display("FAIL w3_pready_one_cycle: got %b expected 0", pready3); end
        @(posedge pclk); #1;
        // Bus changes during WAIT must not affect the latched write.
        sel3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h24; pwdata = 32'h9ABCDEF0;
        @(posedge pclk); #1;
        penable = 1'b1; paddr = 32'h20; pwdata = 32'h0; pwrite = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge pclk);
            if (pready3) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL w3_latch_pready: got 0 expected 1"); end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        apb_xfer(1'b1, 1'b0, 32'h24, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h9ABCDEF0) begin errors++; $display("FAIL w3_latched_data: got %h expected 9abcdef0", rd); end
        apb_xfer(1'b1, 1'b0, 32'h20, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL w3_other_word: got %h expected 12345678", rd); end
    endtask

    task automatic test_errors;
        logic [31:0] rd; logic err; int acc;
        apb_xfer(1'b0, 1'b0, 32'h80, 32'h0, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_range_pslverr: got %b expected 1", err); end
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL err_range_prdata: got %h expected 0", rd); end
        apb_xfer(1'b0, 1'b1, 32'h02, 32'hCAFEF00D, rd, err, acc);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_misalign_pslverr: got %b expected 1", err); end
        checks++; if (err0 !== 8'd2) begin errors++; $display("FAIL err_count_two: got %0d expected 2", err0); end
        apb_xfer(1'b0, 1'b0, 32'h00, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h0 || err !== 1'b0) begin errors++; $display("FAIL err_mem_unchanged: got %h/%b expected 0/0", rd, err); end
        apb_xfer(1'b0, 1'b0, 32'h10, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL err_mem_kept: got %h expected deadbeef", rd); end
        // penable without a setup phase
        sel3 = 1'b0; psel = 1'b1; penable = 1'b1;
        @(negedge pclk);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++; if (err0 !== 8'd3 || pready0 !== 1'b0) begin errors++; $display("FAIL err_no_setup: got cnt %0d pready %b expected 3/0", err0, pready0); end
        @(posedge pclk); #1;
    endtask

    task automatic test_abort;
        logic [31:0] rd; logic err; int acc; bit any_ready;
        sel3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h40; pwdata = 32'h0BADF00D;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        any_ready = 1'b0;
        repeat (6) begin
            @(negedge pclk);
            if (pready3) any_ready = 1'b1;
        end
        checks++; if (any_ready) begin errors++; $display("FAIL abort_pready: got 1 expected 0"); end
        checks++; if (err3 !== 8'd1) begin errors++; $display("FAIL abort_err_count: got %0d expected 1", err3); end
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", st3); end
        @(posedge pclk); #1;
        apb_xfer(1'b1, 1'b0, 32'h40, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL abort_not_written: got %h expected 0", rd); end
        checks++; if (acc !== 4) begin errors++; $display("FAIL abort_next_latency: got %0d expected 4", acc); end
        apb_xfer(1'b1, 1'b0, 32'h20, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_prior_word: got %h expected 12345678", rd); end
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd; logic err; int acc;
        sel3 = 1'b1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = 32'h14; pwdata = 32'h55AA55AA;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        preset = 1'b1;
        @(negedge pclk);
        checks++; if (pready3 !== 1'b0 || pslverr3 !== 1'b0) begin errors++; $display("FAIL rmid_resp: got %b/%b expected 0/0", pready3, pslverr3); end
        checks++; if (prdata3 !== 32'h0 || prdata0 !== 32'h0) begin errors++; $display("FAIL rmid_prdata: got %h/%h expected 0", prdata3, prdata0); end
        checks++; if (err3 !== 8'h0 || err0 !== 8'h0) begin errors++; $display("FAIL rmid_err_count: got %0d/%0d expected 0", err3, err0); end
        checks++; if (st3 !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d expected 0", st3); end
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        preset = 1'b0;
        @(posedge pclk); #1;
        apb_xfer(1'b1, 1'b0, 32'h14, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_idx5: got %h expected 0", rd); end
        apb_xfer(1'b1, 1'b0, 32'h20, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL rmid_mem_cleared: got %h expected 0", rd); end
    endtask

`ifdef APB_SLV_PSTRB_EN
    task automatic test_pstrb;
        logic [31:0] rd; logic err; int acc;
        strb_val = 4'hF;
        apb_xfer(1'b0, 1'b1, 32'h30, 32'hFFFFFFFF, rd, err, acc);
        strb_val = 4'b0101;
        apb_xfer(1'b0, 1'b1, 32'h30, 32'h11223344, rd, err, acc);
        strb_val = 4'b0000;
        apb_xfer(1'b0, 1'b1, 32'h30, 32'h00000000, rd, err, acc);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL strb_zero_err: got %b expected 0", err); end
        strb_val = 4'b0000;
        apb_xfer(1'b0, 1'b0, 32'h30, 32'h0, rd, err, acc);
        checks++; if (rd !== 32'hFF22FF44) begin errors++; $display("FAIL strb_merge: got %h expected ff22ff44", rd); end
        strb_val = 4'hF;
    endtask
`endif

    task automatic test_back_to_back;
        logic [31:0] rd; logic err; int acc; int start;
        start = cyc;
        for (int i = 0; i < 32; i++) begin
            apb_xfer(1'b0, 1'b1, 32'(i * 4), 32'hA5A50000 | 32'(i * 17), rd, err, acc);
        end
        checks++; if (cyc - start !== 64) begin errors++; $display("FAIL b2b_cycles: got %0d expected 64", cyc - start); end
        for (int i = 0; i < 32; i++) begin
            apb_xfer(1'b0, 1'b0, 32'(i * 4), 32'h0, rd, err, acc);
            checks++;
            if (rd !== (32'hA5A50000 | 32'(i * 17)) || err !== 1'b0 || acc !== 1) begin
                errors++;
                $display("FAIL b2b_read[%0d]: got %h err %b acc %0d expected %h err 0 acc 1",
                         i, rd, err, acc, 32'hA5A50000 | 32'(i * 17));
            end
        end
        checks++; if (err0 !== 8'd0) begin errors++; $display("FAIL b2b_err_count: got %0d expected 0", err0); end
    endtask

    task automatic test_saturation;
        sel3 = 1'b0; psel = 1'b1; penable = 1'b1;
        repeat (300) @(posedge pclk);
        #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        checks++; if (err0 !== 8'hFF) begin errors++; $display("FAIL err_saturate: got %h expected ff", err0); end
        checks++; if (pready0 !== 1'b0) begin errors++; $display("FAIL sat_pready: got %b expected 0", pready0); end
        @(posedge pclk); #1;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_zero_wait();
        test_wait3();
        test_errors();
        test_abort();
        test_reset_mid_wait();
`ifdef APB_SLV_PSTRB_EN
        test_pstrb();
`endif
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
